// File: rtl/nmcu_pkg.sv
// Instruction and response records exchanged between the CPU and the near-memory compute unit.
package nmcu_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 16;
    localparam int PSUM_W = 32;

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_LOAD   = 4'd1;
    localparam logic [3:0] OP_STORE  = 4'd2;
    localparam logic [3:0] OP_MATMUL = 4'd3;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ILLEGAL = 2'b01;
    localparam logic [1:0] ST_RANGE   = 2'b10;

    typedef struct packed {
        logic [3:0]        opcode;
        logic [ADDR_W-1:0] addr_a;
        logic [ADDR_W-1:0] addr_b;
        logic [ADDR_W-1:0] addr_c;
        logic [DATA_W-1:0] data;
        logic [LEN_W-1:0]  len;
        logic [LEN_W-1:0]  n;
        logic [LEN_W-1:0]  m;
        logic [LEN_W-1:0]  k;
    } instr_t;

    typedef struct packed {
        logic [PSUM_W-1:0] data;
        logic [1:0]        status;
    } resp_t;
endpackage

// File: rtl/nmcu.sv
// Near-memory compute unit: single-word LOAD/STORE and a sequential MAC-based MATMUL
// over a local word memory, one instruction outstanding at a time.
module nmcu
    import nmcu_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W,
    parameter int LEN_WIDTH  = LEN_W,
    parameter int PSUM_WIDTH = PSUM_W,
    parameter int MEM_DEPTH  = 16384
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   cpu_instr_valid,
    input  instr_t cpu_instruction,
    output logic   cpu_instr_ready,
    output logic   nmcu_resp_valid_o,
    input  logic   nmcu_resp_ready_i,
    output resp_t  nmcu_response_o
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_EXEC = 3'd1;
    localparam logic [2:0] S_MAC  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    localparam int IW = $clog2(MEM_DEPTH);
    // Wide enough that base + dim*dim can never wrap before the range compare.
    localparam int WW = ADDR_WIDTH + 2 * LEN_WIDTH + 1;
    localparam logic [WW-1:0] DEPTH = WW'(MEM_DEPTH);

    logic [PSUM_WIDTH-1:0] mem [MEM_DEPTH];

    logic [2:0]            state;
    instr_t                ins;
    logic [LEN_WIDTH-1:0]  i_c, j_c, k_c;
    logic [PSUM_WIDTH-1:0] acc;
    resp_t                 resp;

    logic [WW-1:0]         a_idx, b_idx, c_idx, a_end, b_end, c_end;
    logic [PSUM_WIDTH-1:0] a_word, b_word, prod;
    logic                  addr_ok, dim_zero, mm_range_ok;
    logic                  last_i, last_j, last_k;
    logic                  mem_we;
    logic [IW-1:0]         mem_waddr;
    logic [PSUM_WIDTH-1:0] mem_wdata;
    logic                  unused_bits;

    assign a_idx = WW'(ins.addr_a) + WW'(i_c) * WW'(ins.k) + WW'(k_c);
    assign b_idx = WW'(ins.addr_b) + WW'(k_c) * WW'(ins.m) + WW'(j_c);
    assign c_idx = WW'(ins.addr_c) + WW'(i_c) * WW'(ins.m) + WW'(j_c);
    assign a_end = WW'(ins.addr_a) + WW'(ins.n) * WW'(ins.k);
    assign b_end = WW'(ins.addr_b) + WW'(ins.k) * WW'(ins.m);
    assign c_end = WW'(ins.addr_c) + WW'(ins.n) * WW'(ins.m);

    assign addr_ok     = WW'(ins.addr_a) < DEPTH;
    assign dim_zero    = (ins.n == '0) || (ins.m == '0) || (ins.k == '0);
    assign mm_range_ok = (a_end <= DEPTH) && (b_end <= DEPTH) && (c_end <= DEPTH);

    assign last_i = (i_c == ins.n - LEN_WIDTH'(1));
    assign last_j = (j_c == ins.m - LEN_WIDTH'(1));
    assign last_k = (k_c == ins.k - LEN_WIDTH'(1));

    assign a_word = mem[a_idx[IW-1:0]];
    assign b_word = mem[b_idx[IW-1:0]];
    assign prod   = PSUM_WIDTH'(a_word[DATA_WIDTH-1:0]) * PSUM_WIDTH'(b_word[DATA_WIDTH-1:0]);

    assign unused_bits = ^{ins.len, a_idx[WW-1:IW], b_idx[WW-1:IW], c_idx[WW-1:IW],
                           a_word[PSUM_WIDTH-1:DATA_WIDTH], b_word[PSUM_WIDTH-1:DATA_WIDTH]};

    assign cpu_instr_ready   = (state == S_IDLE);
    assign nmcu_resp_valid_o = (state == S_RESP);
    assign nmcu_response_o   = resp;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (!rst && state == S_EXEC && ins.opcode == OP_STORE && addr_ok) begin
            mem_we    = 1'b1;
            mem_waddr = ins.addr_a[IW-1:0];
            mem_wdata = PSUM_WIDTH'(ins.data);
        end else if (!rst && state == S_WR) begin
            mem_we    = 1'b1;
            mem_waddr = c_idx[IW-1:0];
            mem_wdata = acc;
        end
    end

    // Memory has no reset: contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            ins   <= '0;
            i_c   <= '0;
            j_c   <= '0;
            k_c   <= '0;
            acc   <= '0;
            resp  <= '0;
        end else begin
            case (state)
                S_IDLE: if (cpu_instr_valid) begin
                    ins   <= cpu_instruction;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    resp  <= '0;
                    state <= S_RESP;
                    i_c   <= '0;
                    j_c   <= '0;
                    k_c   <= '0;
                    acc   <= '0;
                    case (ins.opcode)
                        OP_NOP: ;
                        OP_LOAD, OP_STORE: begin
                            if (!addr_ok) resp.status <= ST_RANGE;
                            else if (ins.opcode == OP_LOAD) resp.data <= mem[ins.addr_a[IW-1:0]];
                        end
                        OP_MATMUL: begin
                            if (!dim_zero) begin
                                if (!mm_range_ok) resp.status <= ST_RANGE;
                                else state <= S_MAC;
                            end
                        end
                        default: resp.status <= ST_ILLEGAL;
                    endcase
                end
                S_MAC: begin
                    // First term of each output overwrites the previous sum.
                    acc <= ((k_c == '0) ? '0 : acc) + prod;
                    if (last_k) begin
                        k_c   <= '0;
                        state <= S_WR;
                    end else begin
                        k_c <= k_c + LEN_WIDTH'(1);
                    end
                end
                S_WR: begin
                    state <= S_MAC;
                    if (!last_j) begin
                        j_c <= j_c + LEN_WIDTH'(1);
                    end else begin
                        j_c <= '0;
                        if (last_i) state <= S_RESP;
                        else        i_c <= i_c + LEN_WIDTH'(1);
                    end
                end
                S_RESP: if (nmcu_resp_ready_i) begin
                    state <= S_IDLE;
                    resp  <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nmcu.sv
// Scoreboard bench for nmcu: the driver queues expected responses, a monitor checks them on arrival.
module tb_nmcu;
    import nmcu_pkg::*;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   cpu_instr_valid = 1'b0;
    instr_t cpu_instruction = '0;
    logic   cpu_instr_ready;
    logic   nmcu_resp_valid_o;
    logic   nmcu_resp_ready_i = 1'b1;
    resp_t  nmcu_response_o;

    nmcu dut (
        .clk               (clk),
        .rst               (rst),
        .cpu_instr_valid   (cpu_instr_valid),
        .cpu_instruction   (cpu_instruction),
        .cpu_instr_ready   (cpu_instr_ready),
        .nmcu_resp_valid_o (nmcu_resp_valid_o),
        .nmcu_resp_ready_i (nmcu_resp_ready_i),
        .nmcu_response_o   (nmcu_response_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  status;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;
    bit   seen   = 0;

    logic [7:0] ra [32];
    logic [7:0] rb [32];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: one pop per response, at the first cycle it is presented.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 0;
            end else if (nmcu_resp_valid_o && !seen) begin
                seen = 1;
                if (sb.size() == 0) begin
                    check("unexpected_resp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("resp_data", nmcu_response_o.data, e.data);
                    check("resp_status", nmcu_response_o.status, e.status);
                    check("resp_latency", cyc - e.acc, e.lat);
                end
            end else if (!nmcu_resp_valid_o) begin
                seen = 0;
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [7:0] d, input logic [15:0] n,
                         input logic [15:0] m, input logic [15:0] k, input logic [31:0] ed,
                         input logic [1:0] es, input int el, input bit push);
        exp_t e;
        int   t;
        @(negedge clk);
        cpu_instruction = '{opcode:op, addr_a:a, addr_b:b, addr_c:c, data:d,
                            len:16'd3, n:n, m:m, k:k};
        cpu_instr_valid = 1'b1;
        t = 0;
        while (!cpu_instr_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!cpu_instr_ready) begin
            check("accept_timeout", 0, 1);
            cpu_instr_valid = 1'b0;
            return;
        end
        e.data = ed; e.status = es; e.lat = el; e.acc = cyc;
        if (push) sb.push_back(e);
        @(negedge clk);
        cpu_instr_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((sb.size() != 0 || nmcu_resp_valid_o) && t < 2000);
        if (t >= 2000) check("done_timeout", 0, 1);
    endtask

    task automatic store(input logic [15:0] a, input logic [7:0] d, input logic [1:0] es);
        issue(OP_STORE, a, 16'd0, 16'd0, d, 16'd0, 16'd0, 16'd0, 32'd0, es, 2, 1);
        wait_done();
    endtask

    task automatic load(input logic [15:0] a, input logic [31:0] ed, input logic [1:0] es);
        issue(OP_LOAD, a, 16'd0, 16'd0, 8'd0, 16'd0, 16'd0, 16'd0, ed, es, 2, 1);
        wait_done();
    endtask

    initial begin
        int t;
        logic [31:0] s;

        repeat (3) @(negedge clk);
        check("rst_ready", cpu_instr_ready, 1);
        check("rst_valid", nmcu_resp_valid_o, 0);
        check("rst_response", nmcu_response_o, 0);
        rst = 1'b0;

        // Single-word store then load back.
        store(16'h0005, 8'd9, ST_OK);
        load(16'h0005, 32'd9, ST_OK);

        // 2x2 matmul with hand-computed product.
        store(16'h0000, 8'd1, ST_OK); store(16'h0001, 8'd2, ST_OK);
        store(16'h0002, 8'd3, ST_OK); store(16'h0003, 8'd4, ST_OK);
        store(16'h1000, 8'd5, ST_OK); store(16'h1001, 8'd6, ST_OK);
        store(16'h1002, 8'd7, ST_OK); store(16'h1003, 8'd8, ST_OK);
        issue(OP_MATMUL, 16'h0000, 16'h1000, 16'h2000, 8'd0, 16'd2, 16'd2, 16'd2, 32'd0, ST_OK, 14, 1);
        wait_done();
        load(16'h2000, 32'd19, ST_OK);
        load(16'h2001, 32'd22, ST_OK);
        load(16'h2002, 32'd43, ST_OK);
        load(16'h2003, 32'd50, ST_OK);

        // 4x8x4 matmul with random 0..15 operands against a bench-side golden product.
        for (int x = 0; x < 32; x++) begin
            ra[x] = 8'($urandom_range(0, 15));
            rb[x] = 8'($urandom_range(0, 15));
            store(16'h0100 + 16'(x), ra[x], ST_OK);
            store(16'h0200 + 16'(x), rb[x], ST_OK);
        end
        issue(OP_MATMUL, 16'h0100, 16'h0200, 16'h0300, 8'd0, 16'd4, 16'd4, 16'd8, 32'd0, ST_OK, 146, 1);
        wait_done();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int k = 0; k < 8; k++) s += 32'(ra[i*8+k]) * 32'(rb[k*4+j]);
                load(16'h0300 + 16'(i*4 + j), s, ST_OK);
            end
        end

        // Error cases.
        issue(4'd7, 16'h0000, 16'h0000, 16'h0000, 8'd0, 16'd0, 16'd0, 16'd0, 32'd0, ST_ILLEGAL, 2, 1);
        wait_done();
        load(16'h4000, 32'd0, ST_RANGE);
        store(16'h4000, 8'd1, ST_RANGE);
        store(16'h3FFF, 8'hAA, ST_OK);
        issue(OP_MATMUL, 16'h0000, 16'h1000, 16'h3FFF, 8'd0, 16'd2, 16'd2, 16'd2, 32'd0, ST_RANGE, 2, 1);
        wait_done();
        load(16'h3FFF, 32'hAA, ST_OK);
        issue(OP_MATMUL, 16'h0000, 16'h1000, 16'h2000, 8'd0, 16'd0, 16'd2, 16'd2, 32'd0, ST_OK, 2, 1);
        wait_done();
        load(16'h2000, 32'd19, ST_OK);
        issue(OP_NOP, 16'h0000, 16'h0000, 16'h0000, 8'd0, 16'd0, 16'd0, 16'd0, 32'd0, ST_OK, 2, 1);
        wait_done();

        // Back-pressure: response must hold while ready is low.
        nmcu_resp_ready_i = 1'b0;
        issue(OP_LOAD, 16'h0005, 16'd0, 16'd0, 8'd0, 16'd0, 16'd0, 16'd0, 32'd9, ST_OK, 2, 1);
        t = 0;
        while (!nmcu_resp_valid_o && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("hold_resp_seen", nmcu_resp_valid_o, 1);
        repeat (5) begin
            @(negedge clk);
            check("hold_valid", nmcu_resp_valid_o, 1);
            check("hold_data", nmcu_response_o.data, 9);
            check("hold_instr_ready", cpu_instr_ready, 0);
        end
        nmcu_resp_ready_i = 1'b1;
        @(negedge clk);
        check("release_idle_ready", cpu_instr_ready, 1);
        check("release_valid", nmcu_resp_valid_o, 0);
        wait_done();

        // Reset mid-MATMUL: no response, then normal traffic resumes.
        issue(OP_MATMUL, 16'h0100, 16'h0200, 16'h0400, 8'd0, 16'd4, 16'd4, 16'd8, 32'd0, ST_OK, 146, 0);
        repeat (20) @(negedge clk);
        check("mac_busy_ready", cpu_instr_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", cpu_instr_ready, 1);
        check("abort_valid", nmcu_resp_valid_o, 0);
        repeat (160) @(negedge clk);
        check("abort_no_resp", nmcu_resp_valid_o, 0);
        store(16'h0007, 8'h33, ST_OK);
        load(16'h0007, 32'h33, ST_OK);

        repeat (5) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
